usbfs_link_ctrl: RTL and testbench
==================================

USBFS_LINK_CTRL -- requirements
Module: usbfs_link_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 60000000, clk frequency in Hz.
REQ-002 SHALL have parameter CONNECT_MS, default 1000, pull-up-off time after connect request, in ms.
REQ-003 SHALL have parameter RESET_US, default 5, minimum SE0 time counted as host bus reset, in us.
REQ-004 SHALL have parameter SUSPEND_MS, default 3, idle-J time before suspend, in ms.
REQ-005 SHALL have parameter WAKEUP_MS, default 2, device-driven K time for remote wakeup, in ms.
REQ-006 SHALL have port clk  input  1  the single clock.
REQ-007 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port soft_connect  input  1  1 = attach to bus, 0 = detach.
REQ-009 SHALL have ports usb_dp_rx, usb_dn_rx  input  1 each  raw D+/D- pad levels, asynchronous.
REQ-010 SHALL have port usb_dp_pull  output  1  enables the 1.5k D+ pull-up.
REQ-011 SHALL have port usb_rstn  output  1  active-low reset to the downstream USB core.
REQ-012 SHALL have ports bus_reset  output  1  one-cycle pulse at bus-reset entry; suspend  output  1  bus suspended.
REQ-013 SHALL have port line_state  output  2  synchronised {dp,dn}.
REQ-014 SHALL have ports wakeup_req input 1, and wk_oe, wk_dp, wk_dn output 1 each (wakeup drive).

Function
REQ-015 SHALL pass dp/dn through a 2-flop synchroniser; line_state lags pads by 2 cycles; J=10, K=01, SE0=00.
REQ-016 SHALL derive cycle counts as CLK_FREQ_HZ/1000*ms and CLK_FREQ_HZ/1000000*us, using 32-bit saturating counters.
REQ-017 SHALL implement states DISCONNECTED, CONNECT_WAIT, ATTACHED, ACTIVE, BUS_RESET, SUSPENDED, RESUME, WAKEUP.
REQ-018 SHALL enter DISCONNECTED on the next clk edge from any state when soft_connect=0; this has highest priority.
REQ-019 DISCONNECTED: usb_dp_pull=0, usb_rstn=0; soft_connect=1 -> CONNECT_WAIT with counter cleared.
REQ-020 CONNECT_WAIT: usb_dp_pull=0, usb_rstn=0; after CONNECT cycles -> ATTACHED.
REQ-021 ATTACHED: usb_dp_pull=1, usb_rstn=0; line_state J or K -> ACTIVE.
REQ-022 ACTIVE: usb_dp_pull=1, usb_rstn=1; RESET consecutive SE0 cycles -> BUS_RESET; SUSPEND consecutive J cycles -> SUSPENDED; any other line state clears the corresponding run counter.
REQ-023 BUS_RESET: usb_rstn=0; bus_reset=1 on the entry cycle only; line J or K -> ACTIVE.
REQ-024 SUSPENDED: suspend=1, usb_rstn=1; K -> RESUME; RESET consecutive SE0 cycles -> BUS_RESET.
REQ-025 RESUME: suspend=1; any non-K line state -> ACTIVE with suspend=0.
REQ-026 SHALL hold wk_oe=0 and wk_dp=wk_dn=0 in all states except WAKEUP.
REQ-027 SE0 and J run counters SHALL clear on every state change.

Reset
REQ-028 With rst=1 at a clk edge: state=DISCONNECTED, usb_dp_pull=0, usb_rstn=0, bus_reset=0, suspend=0, wk_oe=0, all counters 0, synchroniser flops 0.
REQ-029 rst asserted mid-operation, including during WAKEUP, SHALL release the bus (wk_oe=0) on the same edge.

Configuration
REQ-030 Macro USBFS_REMOTE_WAKEUP_EN defined: in SUSPENDED, wakeup_req=1 after at least 5 ms in suspend -> WAKEUP.
REQ-031 With USBFS_REMOTE_WAKEUP_EN defined, WAKEUP SHALL drive wk_oe=1, wk_dp=0, wk_dn=1 for WAKEUP cycles, ignore line_state, then -> RESUME.
REQ-032 Macro undefined: wakeup_req is ignored, WAKEUP is unreachable, and wk_oe, wk_dp, wk_dn are tied to 0.

Verification
REQ-033 CLK_FREQ_HZ=1000000, CONNECT_MS=1, soft_connect=1, pads J -> usb_dp_pull rises exactly 1000 cycles after CONNECT_WAIT entry; usb_rstn=1 on the next edge.
REQ-034 ACTIVE, SE0 for 4 us then J, then SE0 for 5 us -> no reset after the 4 us SE0; bus_reset pulses once, usb_rstn=0 until J returns.
REQ-035 ACTIVE, constant J for 3 ms -> suspend=1 at cycle 3000; a K then SE0 -> suspend=0, state ACTIVE.
REQ-036 With the macro defined, suspended for 6 ms, wakeup_req pulse -> wk_oe=1 with K driven for 2000 cycles, then RESUME.
REQ-037 soft_connect dropped during SUSPENDED, or rst=1 during WAKEUP -> usb_dp_pull=0, usb_rstn=0, wk_oe=0 on the next edge.

Source files
------------

// File: rtl/usbfs_link_ctrl.sv
// usbfs_link_ctrl: USB full-speed device link-state controller.
// Optional remote wakeup is built in when USBFS_REMOTE_WAKEUP_EN is defined.

module usbfs_link_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 60000000,
    parameter int unsigned CONNECT_MS  = 1000,
    parameter int unsigned RESET_US    = 5,
    parameter int unsigned SUSPEND_MS  = 3,
    parameter int unsigned WAKEUP_MS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_connect,
    input  logic       usb_dp_rx,
    input  logic       usb_dn_rx,
    output logic       usb_dp_pull,
    output logic       usb_rstn,
    output logic       bus_reset,
    output logic       suspend,
    output logic [1:0] line_state,
    input  logic       wakeup_req,
    output logic       wk_oe,
    output logic       wk_dp,
    output logic       wk_dn
);

    typedef enum logic [2:0] {
        S_DISC,
        S_CONN_WAIT,
        S_ATTACHED,
        S_ACTIVE,
        S_BUS_RESET,
        S_SUSPENDED,
        S_RESUME,
        S_WAKEUP
    } state_t;

    function automatic logic [31:0] f_sat(input longint unsigned v);
        logic [63:0] t;
        t = v;
        f_sat = (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
    endfunction

    function automatic logic [31:0] f_inc(input logic [31:0] v);
        f_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic f_reached(input logic [31:0] cnt,
                                       input logic [31:0] lim);
        f_reached = ({1'b0, cnt} + 33'd1) >= {1'b0, lim};
    endfunction

    localparam longint unsigned L_PER_MS = 64'(CLK_FREQ_HZ / 1000);
    localparam longint unsigned L_PER_US = 64'(CLK_FREQ_HZ / 1000000);

    localparam logic [31:0] C_CONNECT = f_sat(L_PER_MS * 64'(CONNECT_MS));
    localparam logic [31:0] C_RESET   = f_sat(L_PER_US * 64'(RESET_US));
    localparam logic [31:0] C_SUSPEND = f_sat(L_PER_MS * 64'(SUSPEND_MS));

`ifdef USBFS_REMOTE_WAKEUP_EN
    localparam logic [31:0] C_WAKEUP  = f_sat(L_PER_MS * 64'(WAKEUP_MS));
    localparam logic [31:0] C_WK_MIN  = f_sat(L_PER_MS * 64'd5);
`endif

    localparam logic [1:0] L_SE0 = 2'b00;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_J   = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic        r_dp_s1;
    logic        r_dp_s2;
    logic        r_dn_s1;
    logic        r_dn_s2;
    logic [31:0] r_cnt;
    logic [31:0] r_se0_cnt;
    logic [31:0] r_j_cnt;
    logic        r_bus_reset;

    logic [1:0]  w_line;
    logic        w_line_se0;
    logic        w_line_j;
    logic        w_line_k;
    logic        w_conn_done;
    logic        w_se0_done;
    logic        w_j_done;

`ifdef USBFS_REMOTE_WAKEUP_EN
    logic        w_wk_done;
    logic        w_wk_allowed;
`endif

    // Two-flop synchroniser for the asynchronous pad levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_s1 <= 1'b0;
            r_dp_s2 <= 1'b0;
            r_dn_s1 <= 1'b0;
            r_dn_s2 <= 1'b0;
        end else begin
            r_dp_s1 <= usb_dp_rx;
            r_dp_s2 <= r_dp_s1;
            r_dn_s1 <= usb_dn_rx;
            r_dn_s2 <= r_dn_s1;
        end
    end

    assign w_line     = {r_dp_s2, r_dn_s2};
    assign line_state = w_line;
    assign w_line_se0 = (w_line == L_SE0);
    assign w_line_j   = (w_line == L_J);
    assign w_line_k   = (w_line == L_K);

    // A run is complete on the cycle that would make it the N-th in a row.
    assign w_conn_done = f_reached(r_cnt, C_CONNECT);
    assign w_se0_done  = w_line_se0 && f_reached(r_se0_cnt, C_RESET);
    assign w_j_done    = w_line_j && f_reached(r_j_cnt, C_SUSPEND);

`ifdef USBFS_REMOTE_WAKEUP_EN
    assign w_wk_done    = f_reached(r_cnt, C_WAKEUP);
    assign w_wk_allowed = ({1'b0, r_cnt} >= {1'b0, C_WK_MIN});
`endif

    // State register; reset and detach both land in DISCONNECTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DISC;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a dropped soft_connect overrides everything.
    always_comb begin
        w_next = r_state;
        if (!soft_connect) begin
            w_next = S_DISC;
        end else begin
            unique case (r_state)
                S_DISC: begin
                    w_next = S_CONN_WAIT;
                end
                S_CONN_WAIT: begin
                    if (w_conn_done) w_next = S_ATTACHED;
                end
                S_ATTACHED: begin
                    if (w_line_j || w_line_k) w_next = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_se0_done) w_next = S_BUS_RESET;
                    else if (w_j_done) w_next = S_SUSPENDED;
                end
                S_BUS_RESET: begin
                    if (w_line_j || w_line_k) w_next = S_ACTIVE;
                end
                S_SUSPENDED: begin
                    if (w_line_k) w_next = S_RESUME;
                    else if (w_se0_done) w_next = S_BUS_RESET;
`ifdef USBFS_REMOTE_WAKEUP_EN
                    else if (wakeup_req && w_wk_allowed) w_next = S_WAKEUP;
`endif
                end
                S_RESUME: begin
                    if (!w_line_k) w_next = S_ACTIVE;
                end
`ifdef USBFS_REMOTE_WAKEUP_EN
                S_WAKEUP: begin
                    if (w_wk_done) w_next = S_RESUME;
                end
`endif
                default: begin
                    w_next = S_DISC;
                end
            endcase
        end
    end

    // Dwell and line-run counters; all restart whenever the state moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 32'd0;
            r_se0_cnt <= 32'd0;
            r_j_cnt   <= 32'd0;
        end else if (w_next != r_state) begin
            r_cnt     <= 32'd0;
            r_se0_cnt <= 32'd0;
            r_j_cnt   <= 32'd0;
        end else begin
            r_cnt     <= f_inc(r_cnt);
            r_se0_cnt <= w_line_se0 ? f_inc(r_se0_cnt) : 32'd0;
            r_j_cnt   <= w_line_j ? f_inc(r_j_cnt) : 32'd0;
        end
    end

    // Single-cycle pulse aligned with the first cycle spent in BUS_RESET.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_reset <= 1'b0;
        end else begin
            r_bus_reset <= (w_next == S_BUS_RESET) &&
                           (r_state != S_BUS_RESET);
        end
    end

    assign bus_reset = r_bus_reset;

    // Moore outputs decoded from the current state.
    always_comb begin
        usb_dp_pull = 1'b0;
        usb_rstn    = 1'b0;
        suspend     = 1'b0;
        unique case (r_state)
            S_DISC, S_CONN_WAIT: begin
                usb_dp_pull = 1'b0;
            end
            S_ATTACHED, S_BUS_RESET: begin
                usb_dp_pull = 1'b1;
            end
            S_ACTIVE: begin
                usb_dp_pull = 1'b1;
                usb_rstn    = 1'b1;
            end
            S_SUSPENDED, S_RESUME, S_WAKEUP: begin
                usb_dp_pull = 1'b1;
                usb_rstn    = 1'b1;
                suspend     = 1'b1;
            end
            default: begin
                usb_dp_pull = 1'b0;
            end
        endcase
    end

`ifdef USBFS_REMOTE_WAKEUP_EN
    assign wk_oe = (r_state == S_WAKEUP);
    assign wk_dp = 1'b0;
    assign wk_dn = (r_state == S_WAKEUP);
`else
    logic w_unused_wakeup;
    assign w_unused_wakeup = wakeup_req;
    assign wk_oe = 1'b0;
    assign wk_dp = 1'b0;
    assign wk_dn = 1'b0;
`endif

endmodule

// File: tb/tb_usbfs_link_ctrl.sv
// tb_usbfs_link_ctrl: directed bench for usbfs_link_ctrl at a 1 MHz clock.
// Covers connect timing, bus reset, suspend/resume, wakeup and detach.

module tb_usbfs_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_connect;
    logic       usb_dp_rx;
    logic       usb_dn_rx;
    logic       usb_dp_pull;
    logic       usb_rstn;
    logic       bus_reset;
    logic       suspend;
    logic [1:0] line_state;
    logic       wakeup_req;
    logic       wk_oe;
    logic       wk_dp;
    logic       wk_dn;

    int n_checks = 0;
    int n_fail   = 0;

    usbfs_link_ctrl #(
        .CLK_FREQ_HZ(1000000),
        .CONNECT_MS (1),
        .RESET_US   (5),
        .SUSPEND_MS (3),
        .WAKEUP_MS  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_connect(soft_connect),
        .usb_dp_rx   (usb_dp_rx),
        .usb_dn_rx   (usb_dn_rx),
        .usb_dp_pull (usb_dp_pull),
        .usb_rstn    (usb_rstn),
        .bus_reset   (bus_reset),
        .suspend     (suspend),
        .line_state  (line_state),
        .wakeup_req  (wakeup_req),
        .wk_oe       (wk_oe),
        .wk_dp       (wk_dp),
        .wk_dn       (wk_dn)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pads(input logic [1:0] v);
        usb_dp_rx = v[1];
        usb_dn_rx = v[0];
    endtask

    task automatic wait_suspend();
        for (int i = 0; i < 3200 && suspend !== 1'b1; i++) step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        soft_connect = 1'b0;
        wakeup_req = 1'b0;
        set_pads(2'b10);
        step(3);
        n_checks++;
        if (usb_dp_pull !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pull: got %b want 0", usb_dp_pull);
        end
        n_checks++;
        if (usb_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rstn: got %b want 0", usb_rstn);
        end
        n_checks++;
        if ({bus_reset, suspend} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_flags: got %b want 00", {bus_reset, suspend});
        end
        n_checks++;
        if ({wk_oe, wk_dp, wk_dn} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_wk: got %b want 000", {wk_oe, wk_dp, wk_dn});
        end
        n_checks++;
        if (line_state !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_line: got %b want 00", line_state);
        end
    endtask

    task automatic test_connect();
        rst = 1'b0;
        step(3);
        n_checks++;
        if (line_state !== 2'b10) begin
            n_fail++;
            $display("FAIL sync_line: got %b want 10", line_state);
        end
        n_checks++;
        if (usb_dp_pull !== 1'b0) begin
            n_fail++;
            $display("FAIL detached_pull: got %b want 0", usb_dp_pull);
        end
        soft_connect = 1'b1;
        step(1);
        step(999);
        n_checks++;
        if (usb_dp_pull !== 1'b0) begin
            n_fail++;
            $display("FAIL conn_999: got %b want 0", usb_dp_pull);
        end
        step(1);
        n_checks++;
        if ({usb_dp_pull, usb_rstn} !== 2'b10) begin
            n_fail++;
            $display("FAIL conn_1000: got %b want 10",
                     {usb_dp_pull, usb_rstn});
        end
        step(1);
        n_checks++;
        if (usb_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL conn_active: got %b want 1", usb_rstn);
        end
    endtask

    task automatic test_bus_reset();
        int pulses;
        int low;
        pulses = 0;
        low = 0;
        set_pads(2'b00);
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus_reset === 1'b1) pulses++;
            if (usb_rstn !== 1'b1) low++;
        end
        set_pads(2'b10);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus_reset === 1'b1) pulses++;
            if (usb_rstn !== 1'b1) low++;
        end
        n_checks++;
        if (pulses != 0 || low != 0) begin
            n_fail++;
            $display("FAIL se0_4us: got pulses=%0d low=%0d want 0 0",
                     pulses, low);
        end
        set_pads(2'b00);
        step(6);
        n_checks++;
        if ({bus_reset, usb_rstn} !== 2'b01) begin
            n_fail++;
            $display("FAIL se0_pre: got %b want 01", {bus_reset, usb_rstn});
        end
        step(1);
        n_checks++;
        if ({bus_reset, usb_rstn} !== 2'b10) begin
            n_fail++;
            $display("FAIL se0_entry: got %b want 10",
                     {bus_reset, usb_rstn});
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus_reset === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || usb_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL se0_hold: got pulses=%0d rstn=%b want 0 0",
                     pulses, usb_rstn);
        end
        set_pads(2'b10);
        step(2);
        n_checks++;
        if (usb_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL j_sync: got %b want 0", usb_rstn);
        end
        step(1);
        n_checks++;
        if (usb_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL j_active: got %b want 1", usb_rstn);
        end
    endtask

    task automatic test_suspend();
        step(2999);
        n_checks++;
        if (suspend !== 1'b0) begin
            n_fail++;
            $display("FAIL susp_2999: got %b want 0", suspend);
        end
        step(1);
        n_checks++;
        if ({suspend, usb_rstn, usb_dp_pull} !== 3'b111) begin
            n_fail++;
            $display("FAIL susp_3000: got %b want 111",
                     {suspend, usb_rstn, usb_dp_pull});
        end
        set_pads(2'b01);
        step(5);
        n_checks++;
        if (suspend !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_k: got %b want 1", suspend);
        end
        set_pads(2'b00);
        step(2);
        n_checks++;
        if (suspend !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_hold: got %b want 1", suspend);
        end
        step(1);
        n_checks++;
        if ({suspend, usb_rstn, usb_dp_pull} !== 3'b011) begin
            n_fail++;
            $display("FAIL resume_active: got %b want 011",
                     {suspend, usb_rstn, usb_dp_pull});
        end
        set_pads(2'b10);
        step(5);
    endtask

    task automatic test_suspend_reset();
        int pulses;
        pulses = 0;
        wait_suspend();
        n_checks++;
        if (suspend !== 1'b1) begin
            n_fail++;
            $display("FAIL susp2_timeout: got %b want 1", suspend);
        end
        set_pads(2'b00);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus_reset === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || {suspend, usb_rstn} !== 2'b00) begin
            n_fail++;
            $display("FAIL susp_se0: got pulses=%0d s/r=%b want 1 00",
                     pulses, {suspend, usb_rstn});
        end
        set_pads(2'b10);
        step(3);
        n_checks++;
        if (usb_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL susp_se0_j: got %b want 1", usb_rstn);
        end
    endtask

    task automatic test_wakeup();
        wait_suspend();
        n_checks++;
        if (suspend !== 1'b1) begin
            n_fail++;
            $display("FAIL susp3_timeout: got %b want 1", suspend);
        end
`ifdef USBFS_REMOTE_WAKEUP_EN
        step(1000);
        wakeup_req = 1'b1;
        step(1);
        wakeup_req = 1'b0;
        n_checks++;
        if ({wk_oe, suspend} !== 2'b01) begin
            n_fail++;
            $display("FAIL wk_early: got %b want 01", {wk_oe, suspend});
        end
        step(5500);
        wakeup_req = 1'b1;
        step(1);
        wakeup_req = 1'b0;
        n_checks++;
        if ({wk_oe, wk_dp, wk_dn} !== 3'b101) begin
            n_fail++;
            $display("FAIL wk_start: got %b want 101", {wk_oe, wk_dp, wk_dn});
        end
        step(1999);
        n_checks++;
        if ({wk_oe, wk_dp, wk_dn} !== 3'b101) begin
            n_fail++;
            $display("FAIL wk_2000: got %b want 101", {wk_oe, wk_dp, wk_dn});
        end
        step(1);
        n_checks++;
        if ({wk_oe, wk_dn, suspend} !== 3'b001) begin
            n_fail++;
            $display("FAIL wk_resume: got %b want 001",
                     {wk_oe, wk_dn, suspend});
        end
        step(1);
        n_checks++;
        if ({suspend, usb_rstn} !== 2'b01) begin
            n_fail++;
            $display("FAIL wk_active: got %b want 01", {suspend, usb_rstn});
        end
`else
        wakeup_req = 1'b1;
        step(3);
        n_checks++;
        if ({wk_oe, wk_dp, wk_dn, suspend} !== 4'b0001) begin
            n_fail++;
            $display("FAIL wk_ignored: got %b want 0001",
                     {wk_oe, wk_dp, wk_dn, suspend});
        end
        wakeup_req = 1'b0;
`endif
    endtask

    task automatic test_rst_midop();
        wait_suspend();
`ifdef USBFS_REMOTE_WAKEUP_EN
        step(5100);
        wakeup_req = 1'b1;
        step(1);
        wakeup_req = 1'b0;
        n_checks++;
        if (wk_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rwk_enter: got %b want 1", wk_oe);
        end
        step(10);
`endif
        rst = 1'b1;
        step(1);
        n_checks++;
        if ({usb_dp_pull, usb_rstn, suspend, wk_oe} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid: got %b want 0000",
                     {usb_dp_pull, usb_rstn, suspend, wk_oe});
        end
        rst = 1'b0;
        for (int i = 0; i < 1100 && usb_rstn !== 1'b1; i++) step(1);
        n_checks++;
        if (usb_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL reconnect: got %b want 1", usb_rstn);
        end
    endtask

    task automatic test_disconnect();
        wait_suspend();
        n_checks++;
        if (suspend !== 1'b1) begin
            n_fail++;
            $display("FAIL susp4_timeout: got %b want 1", suspend);
        end
        soft_connect = 1'b0;
        step(1);
        n_checks++;
        if ({usb_dp_pull, usb_rstn, suspend, wk_oe} !== 4'b0000) begin
            n_fail++;
            $display("FAIL detach: got %b want 0000",
                     {usb_dp_pull, usb_rstn, suspend, wk_oe});
        end
    endtask

    initial begin
        test_reset();
        test_connect();
        test_bus_reset();
        test_suspend();
        test_suspend_reset();
        test_wakeup();
        test_rst_midop();
        test_disconnect();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
